// File: rtl/axi_merge_resps_n.sv
// Response-channel merge arbiter for the Master NI.
// Picks which slave response channel (B, R, or extra ports) feeds the
// response packetizer. Round-robin across enabled channels. A lockable
// channel keeps the grant from its first accepted beat until its LAST beat
// is accepted. Control/valid path only; the payload mux lives outside.
module axi_merge_resps_n #(
  parameter int              N_CH      = 2,
  parameter logic [N_CH-1:0] LOCK_MASK = '0,
  parameter logic [N_CH-1:0] CH_EN     = '1,
  parameter int              MAX_BEATS = 256,
  parameter int              IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  ch_valid,
  input  logic [N_CH-1:0]  ch_last,
  input  logic             beat_accept,
  output logic [N_CH-1:0]  active_channel,
  output logic [IDX_W-1:0] active_idx,
  output logic             any_grant,
  output logic             locked,
  output logic             lock_err
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [IDX_W-1:0] owner, owner_nx;
  logic [CNT_W-1:0] beat_cnt, cnt_nx;
  logic             err_nx;

  logic [N_CH-1:0]  req;
  logic             scan_hit;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

  // Disabled channels never request, whatever their valid says.
  assign req = ch_valid & CH_EN;

  // Next round-robin position after channel i, wrapping at N_CH.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (int'(i) == N_CH - 1) return '0;
    return i + 1'b1;
  endfunction

  // Round-robin scan: first requester at ptr, ptr+1, ... modulo N_CH.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] j_idx;
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    scan_hit = 1'b0;
    scan_idx = '0;
    j        = 0;
    j_idx    = '0;
    for (int k = 0; k < N_CH; k++) begin
      j = int'(ptr) + k;
      if (j >= N_CH) j = j - N_CH;
      j_idx = IDX_W'(j);
      if (!scan_hit && req[j_idx]) begin
        scan_hit = 1'b1;
        scan_idx = j_idx;
      end
    end
  end

  // Grant: the burst owner while locked (even through valid bubbles),
  // otherwise the combinational scan result.
  always_comb begin
    gnt_any        = (state == LOCKED) || scan_hit;
    gnt_idx        = (state == LOCKED) ? owner : scan_idx;
    active_channel = gnt_any ? (N_CH'(1) << gnt_idx) : '0;
    active_idx     = gnt_any ? gnt_idx : '0;
    any_grant      = gnt_any;
    locked         = (state == LOCKED);
  end

  // Next-state logic: advance pointer, enter/leave lock, count locked beats.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    cnt_nx   = beat_cnt;
    err_nx   = lock_err;
    unique case (state)
      IDLE: begin
        if (beat_accept && scan_hit) begin
          if (LOCK_MASK[scan_idx] && !ch_last[scan_idx]) begin
            state_nx = LOCKED;
            owner_nx = scan_idx;
            cnt_nx   = CNT_W'(1);
          end else begin
            ptr_nx = wrap_inc(scan_idx);
          end
        end
      end
      LOCKED: begin
        if (beat_accept) begin
          if (ch_last[owner]) begin
            state_nx = IDLE;
            ptr_nx   = wrap_inc(owner);
            cnt_nx   = '0;
          end else if (beat_cnt < CNT_W'(MAX_BEATS)) begin
            // Overlong burst is flagged but the lock holds: AXI4 forbids
            // interleaving another channel into an unfinished burst.
            cnt_nx = beat_cnt + 1'b1;
            if (cnt_nx == CNT_W'(MAX_BEATS)) err_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      owner    <= owner_nx;
      beat_cnt <= cnt_nx;
      lock_err <= err_nx;
    end
  end

endmodule

// File: tb/tb_axi_merge_resps_n.sv
// Scoreboard bench for axi_merge_resps_n. Three instances share clk/rst:
//   dut 0: N_CH=4, LOCK_MASK=0010, MAX_BEATS=8  (lock, bubble, overlong, reset)
//   dut 1: N_CH=2, defaults                     (plain per-beat alternation)
//   dut 2: N_CH=4, CH_EN=1011                   (disabled-channel skipping)
// The stimulus pushes hand-computed expectations; a monitor pops and
// compares them on the falling edge.
module tb_axi_merge_resps_n;

  logic clk;
  logic rst;

  logic [3:0] a_valid, a_last, a_ch;
  logic       a_acc, a_any, a_lk, a_err;
  logic [1:0] a_idx;

  logic [1:0] b_valid, b_last, b_ch;
  logic       b_acc, b_any, b_lk, b_err;
  logic [0:0] b_idx;

  logic [3:0] c_valid, c_last, c_ch;
  logic       c_acc, c_any, c_lk, c_err;
  logic [1:0] c_idx;

  axi_merge_resps_n #(
    .N_CH(4), .LOCK_MASK(4'b0010), .CH_EN(4'b1111), .MAX_BEATS(8)
  ) dut_a (
    .clk(clk), .rst(rst), .ch_valid(a_valid), .ch_last(a_last),
    .beat_accept(a_acc), .active_channel(a_ch), .active_idx(a_idx),
    .any_grant(a_any), .locked(a_lk), .lock_err(a_err)
  );

  axi_merge_resps_n dut_b (
    .clk(clk), .rst(rst), .ch_valid(b_valid), .ch_last(b_last),
    .beat_accept(b_acc), .active_channel(b_ch), .active_idx(b_idx),
    .any_grant(b_any), .locked(b_lk), .lock_err(b_err)
  );

  axi_merge_resps_n #(
    .N_CH(4), .LOCK_MASK(4'b0000), .CH_EN(4'b1011), .MAX_BEATS(256)
  ) dut_c (
    .clk(clk), .rst(rst), .ch_valid(c_valid), .ch_last(c_last),
    .beat_accept(c_acc), .active_channel(c_ch), .active_idx(c_idx),
    .any_grant(c_any), .locked(c_lk), .lock_err(c_err)
  );

  typedef struct {
    int         dut;
    int         vec;
    logic [3:0] ch;
    logic [1:0] idx;
    logic       any;
    logic       lk;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   vec_id      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one popped expectation against the selected instance.
  task automatic check(input exp_t e);
    logic [3:0] ch;
    logic [1:0] idx;
    logic       any, lk, err;
    case (e.dut)
      0:       begin ch = a_ch;          idx = a_idx;          any = a_any; lk = a_lk; err = a_err; end
      1:       begin ch = {2'b00, b_ch}; idx = {1'b0, b_idx};  any = b_any; lk = b_lk; err = b_err; end
      default: begin ch = c_ch;          idx = c_idx;          any = c_any; lk = c_lk; err = c_err; end
    endcase
    vectors++;
    if (ch !== e.ch || idx !== e.idx || any !== e.any || lk !== e.lk || err !== e.err) begin
      miscompares++;
      $display("FAIL dut%0d vec%0d: got ch=%b idx=%0d any=%b locked=%b err=%b, want ch=%b idx=%0d any=%b locked=%b err=%b",
               e.dut, e.vec, ch, idx, any, lk, err, e.ch, e.idx, e.any, e.lk, e.err);
    end
  endtask

  // Monitor: drain every expectation pushed during this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check(e);
      end
    end
  end

  task automatic clear_inputs();
    a_valid = '0; a_last = '0; a_acc = 1'b0;
    b_valid = '0; b_last = '0; b_acc = 1'b0;
    c_valid = '0; c_last = '0; c_acc = 1'b0;
  endtask

  task automatic push(input int d, input logic [3:0] ech, input logic [1:0] eidx,
                      input logic elk, input logic eerr);
    vec_id++;
    sb.push_back(exp_t'{d, vec_id, ech, eidx, |ech, elk, eerr});
  endtask

  // One cycle of stimulus on instance d plus its expected outputs.
  task automatic apply(input int d, input logic [3:0] v, input logic [3:0] l,
                       input logic acc, input logic [3:0] ech, input logic [1:0] eidx,
                       input logic elk, input logic eerr);
    @(posedge clk);
    #1;
    clear_inputs();
    case (d)
      0:       begin a_valid = v;      a_last = l;      a_acc = acc; end
      1:       begin b_valid = v[1:0]; b_last = l[1:0]; b_acc = acc; end
      default: begin c_valid = v;      c_last = l;      c_acc = acc; end
    endcase
    push(d, ech, eidx, elk, eerr);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    #12 rst = 1'b1;

    // Reset state, nothing valid.
    apply(0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    apply(1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    apply(2, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Two-channel per-beat alternation.
    apply(1, 4'b0011, 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    apply(1, 4'b0011, 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
    apply(1, 4'b0011, 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    apply(1, 4'b0011, 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
    apply(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0); // accept with no grant
    apply(1, 4'b0010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0);
    apply(1, 4'b0011, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0); // ptr still 0

    // ch1 locked 4-beat burst with ch0, ch2 competing.
    apply(0, 4'b0111, 4'b0101, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0); // ch0 single beat
    apply(0, 4'b0111, 4'b0101, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0); // beat 1 -> lock
    apply(0, 4'b0111, 4'b0101, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0); // beat 2
    apply(0, 4'b0111, 4'b0101, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0); // beat 3
    apply(0, 4'b0111, 4'b0111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0); // beat 4 LAST
    apply(0, 4'b0101, 4'b0101, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0); // ch2 next
    apply(0, 4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0); // ptr=3 wraps to ch0

    // New ch1 burst; owner bubbles for 3 cycles while ch0 waits.
    apply(0, 4'b0011, 4'b0001, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0); // beat 1 -> lock
    for (int i = 0; i < 3; i++)
      apply(0, 4'b0001, 4'b0001, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);

    // Seven more beats without LAST: count reaches 8 on the last of them.
    for (int i = 0; i < 7; i++)
      apply(0, 4'b0011, 4'b0001, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    apply(0, 4'b0011, 4'b0001, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1); // err set, still held
    apply(0, 4'b0011, 4'b0001, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1); // saturated, sticky

    // Asynchronous reset mid-burst, checked before the next rising edge.
    @(posedge clk);
    #1;
    clear_inputs();
    #2 rst = 1'b0;
    push(0, 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;

    // After reset ch0 wins the first tie, then ch1.
    apply(0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    apply(0, 4'b1111, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0);

    // ch2 disabled: order 0,1,3,0; idle accept leaves ptr at 1.
    apply(2, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    apply(2, 4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
    apply(2, 4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b0);
    apply(2, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    apply(2, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    apply(2, 4'b0100, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0); // only disabled ch valid
    apply(2, 4'b1011, 4'b1011, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0);

    @(posedge clk);
    #1 clear_inputs();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
